// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch PC generation, single-outstanding imem requests and
// buffered delivery of {pc, inst} to the IF latch.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [CW:0]   count_after;
    fetch_entry_t  head;
    fetch_entry_t  wdata;
    logic          push;
    logic          pop;
    logic          issue;

    assign push = (state == WAIT) && imem_rvalid && !redirect;
    assign pop  = (count != '0) && !stall && !redirect;

    assign count_after = {1'b0, count}
                       + {{CW{1'b0}}, push}
                       - {{CW{1'b0}}, pop};

    // A new request may go out as soon as the previous one returns.
    assign issue = !rst && !redirect
                && (state == RUN || imem_rvalid)
                && (count_after < (CW+1)'(FIFO_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign wdata     = {req_pc, imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? head.pc   : '0;
    assign if_inst  = if_valid ? head.inst : NOP_INST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            // An in-flight request must still drain before refetching.
            if (state != RUN) state <= imem_rvalid ? RUN : KILL;
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
            state    <= WAIT;
        end else if (state != RUN && imem_rvalid) begin
            state <= RUN;
        end
    end

endmodule
